// File: rtl/sifive_hpm_pkg.sv
// Shared constants, counter-slice state record and mask helper for the HPM counter unit.
package sifive_hpm_pkg;

    localparam int CTR_WIDTH = 64;

    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;
    localparam logic [11:0] MCOUNTINHIBIT = 12'h320;

    typedef struct packed {
        logic [CTR_WIDTH-1:0] cnt;
        logic [31:0]          sel;
        logic                 ovf;
    } hpm_ctr_state_t;

    // Mask with the low 'width' bits set, saturating at 32 bits.
    function automatic logic [31:0] low_mask(input int width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/sifive_hpm_counter.sv
// One HPM counter slice: 64-bit counter, event selector and sticky overflow flag.
module sifive_hpm_counter
    import sifive_hpm_pkg::*;
#(
    parameter int NUM_EVENTS = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] events_q,
    input  logic                  inhibit,
    input  logic                  wr_lo,
    input  logic                  wr_hi,
    input  logic                  wr_sel,
    input  logic [31:0]           wdata,
    output hpm_ctr_state_t        state
);

    localparam logic [31:0] SEL_MASK = low_mask(NUM_EVENTS);

    logic [CTR_WIDTH-1:0] cnt_q;
    logic [31:0]          sel_q;
    logic                 ovf_q;
    logic                 inc;

    // A write to either half drops this cycle's increment outright.
    assign inc = !inhibit && ((32'(events_q) & sel_q) != '0) && !wr_lo && !wr_hi;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sel_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_sel) begin
                sel_q <= wdata & SEL_MASK;
            end
            if (wr_lo) begin
                cnt_q[31:0] <= wdata;
                ovf_q       <= 1'b0;
            end else if (wr_hi) begin
                cnt_q[63:32] <= wdata;
                ovf_q        <= 1'b0;
            end else if (inc) begin
                cnt_q <= cnt_q + 64'd1;
                if (&cnt_q) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign state = '{cnt: cnt_q, sel: sel_q, ovf: ovf_q};

endmodule

// File: rtl/sifive_hpm_counter_unit.sv
// HPM counter unit: event input register, mcountinhibit, CSR decode and read mux
// around NUM_COUNTERS counter slices.
module sifive_hpm_counter_unit
    import sifive_hpm_pkg::*;
#(
    parameter int NUM_COUNTERS = 2,
    parameter int NUM_EVENTS   = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_EVENTS-1:0]   events,
    input  logic                    csr_wen,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    csr_hit,
    output logic [NUM_COUNTERS-1:0] hpm_ovf
);

    localparam logic [31:0] INH_MASK = low_mask(NUM_COUNTERS) << 3;

    logic [NUM_EVENTS-1:0]   events_q;
    logic [31:0]             mcountinhibit_q;
    logic [NUM_COUNTERS-1:0] wr_lo;
    logic [NUM_COUNTERS-1:0] wr_hi;
    logic [NUM_COUNTERS-1:0] wr_sel;
    hpm_ctr_state_t          ctr_state [NUM_COUNTERS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            events_q        <= '0;
            mcountinhibit_q <= '0;
        end else begin
            events_q <= events;
            if (csr_wen && csr_addr == MCOUNTINHIBIT) begin
                mcountinhibit_q <= csr_wdata & INH_MASK;
            end
        end
    end

    always_comb begin
        wr_lo     = '0;
        wr_hi     = '0;
        wr_sel    = '0;
        csr_hit   = (csr_addr == MCOUNTINHIBIT);
        csr_rdata = csr_hit ? mcountinhibit_q : 32'h0;
        for (int n = 0; n < NUM_COUNTERS; n++) begin
            if (csr_addr == MHPMCOUNTER3 + 12'(n)) begin
                wr_lo[n]  = csr_wen;
                csr_hit   = 1'b1;
                csr_rdata = ctr_state[n].cnt[31:0];
            end
            if (csr_addr == MHPMCOUNTER3H + 12'(n)) begin
                wr_hi[n]  = csr_wen;
                csr_hit   = 1'b1;
                csr_rdata = ctr_state[n].cnt[63:32];
            end
            if (csr_addr == MHPMEVENT3 + 12'(n)) begin
                wr_sel[n] = csr_wen;
                csr_hit   = 1'b1;
                csr_rdata = ctr_state[n].sel;
            end
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_ctr
        sifive_hpm_counter #(
            .NUM_EVENTS(NUM_EVENTS)
        ) u_ctr (
            .clock    (clock),
            .reset_n  (reset_n),
            .events_q (events_q),
            .inhibit  (mcountinhibit_q[3+g]),
            .wr_lo    (wr_lo[g]),
            .wr_hi    (wr_hi[g]),
            .wr_sel   (wr_sel[g]),
            .wdata    (csr_wdata),
            .state    (ctr_state[g])
        );
        assign hpm_ovf[g] = ctr_state[g].ovf;
    end

endmodule

// File: tb/tb_sifive_hpm_counter_unit.sv
// Self-checking bench for sifive_hpm_counter_unit: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the counter registers.
module tb_sifive_hpm_counter_unit;

    localparam int N = 2;
    localparam int E = 16;

    logic          clock;
    logic          reset_n;
    logic [E-1:0]  events;
    logic          csr_wen;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_hit;
    logic [N-1:0]  hpm_ovf;

    sifive_hpm_counter_unit #(
        .NUM_COUNTERS(N),
        .NUM_EVENTS  (E)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .events    (events),
        .csr_wen   (csr_wen),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit),
        .hpm_ovf   (hpm_ovf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model state
    logic [63:0]  m_cnt [N];
    logic [31:0]  m_sel [N];
    logic [N-1:0] m_inh;
    logic [N-1:0] m_ovf;
    logic [E-1:0] m_evq;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_cnt[n] = 64'h0;
            m_sel[n] = 32'h0;
        end
        m_inh = '0;
        m_ovf = '0;
        m_evq = '0;
    endtask

    function automatic void exp_rd(input logic [11:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'h0;
        if (a == 12'h320) begin
            hit = 1'b1;
            d   = 32'(m_inh) << 3;
        end
        for (int n = 0; n < N; n++) begin
            if (a == 12'hB03 + 12'(n)) begin hit = 1'b1; d = m_cnt[n][31:0];  end
            if (a == 12'hB83 + 12'(n)) begin hit = 1'b1; d = m_cnt[n][63:32]; end
            if (a == 12'h323 + 12'(n)) begin hit = 1'b1; d = m_sel[n];        end
        end
    endfunction

    // Advance the model by one clock edge using the inputs held during the cycle.
    task automatic model_edge();
        logic wr_ctr;
        if (!reset_n) return;
        for (int n = 0; n < N; n++) begin
            wr_ctr = csr_wen && (csr_addr == 12'hB03 + 12'(n) || csr_addr == 12'hB83 + 12'(n));
            if (!wr_ctr && !m_inh[n] && (m_evq & m_sel[n][E-1:0]) != '0) begin
                if (m_cnt[n] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[n] = 1'b1;
                m_cnt[n] = m_cnt[n] + 64'd1;
            end
        end
        if (csr_wen) begin
            if (csr_addr == 12'h320) m_inh = csr_wdata[3 +: N];
            for (int n = 0; n < N; n++) begin
                if (csr_addr == 12'hB03 + 12'(n)) begin m_cnt[n][31:0]  = csr_wdata; m_ovf[n] = 1'b0; end
                if (csr_addr == 12'hB83 + 12'(n)) begin m_cnt[n][63:32] = csr_wdata; m_ovf[n] = 1'b0; end
                if (csr_addr == 12'h323 + 12'(n)) m_sel[n] = csr_wdata & 32'h0000_FFFF;
            end
        end
        m_evq = events;
    endtask

    task automatic compare_all();
        logic        eh;
        logic [31:0] ed;
        exp_rd(csr_addr, eh, ed);
        check($sformatf("csr_rdata@%03h", csr_addr), 64'(csr_rdata), 64'(ed));
        check($sformatf("csr_hit@%03h", csr_addr), 64'(csr_hit), 64'(eh));
        check("hpm_ovf", 64'(hpm_ovf), 64'(m_ovf));
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, advance model at the edge.
    task automatic cyc(input logic [E-1:0] ev, input logic wen, input logic [11:0] addr,
                       input logic [31:0] wd);
        events    = ev;
        csr_wen   = wen;
        csr_addr  = addr;
        csr_wdata = wd;
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
        cyc('0, 1'b1, addr, wd);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc('0, 1'b0, 12'hB03, 32'h0);
    endtask

    task automatic check_lit(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_wen  = 1'b0;
        events   = '0;
        csr_addr = addr;
        #1;
        check(name, 64'(csr_rdata), 64'(exp));
    endtask

    logic [11:0] addr_tab [12];

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        int          r;

        addr_tab = '{12'h320, 12'h323, 12'h324, 12'h325, 12'hB03, 12'hB04,
                     12'hB05, 12'hB83, 12'hB84, 12'hB00, 12'h000, 12'hC03};

        reset_n   = 1'b0;
        events    = '0;
        csr_wen   = 1'b0;
        csr_addr  = 12'hB03;
        csr_wdata = 32'h0;
        model_reset();
        #2;
        check_lit("reset_cnt3_lo", 12'hB03, 32'h0);
        check("reset_hit", 64'(csr_hit), 64'd1);
        check("reset_ovf", 64'(hpm_ovf), 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Basic counting
        wr(12'h323, 32'h0000_0001);
        for (int i = 0; i < 5; i++) cyc(16'h0001, 1'b0, 12'hB03, 32'h0);
        idle(1);
        check_lit("basic_cnt3", 12'hB03, 32'd5);
        check_lit("basic_cnt4", 12'hB04, 32'd0);

        // Mask and inhibit
        wr(12'h324, 32'h0000_0006);
        for (int i = 0; i < 3; i++) cyc(16'h0006, 1'b0, 12'hB04, 32'h0);
        wr(12'h320, 32'h0000_0010);
        for (int i = 0; i < 3; i++) cyc(16'h0006, 1'b0, 12'hB04, 32'h0);
        idle(2);
        check_lit("mask_cnt4", 12'hB04, 32'd3);
        check_lit("mask_cnt3", 12'hB03, 32'd5);
        wr(12'h320, 32'h0);

        // Wrap-around
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        cyc(16'h0001, 1'b0, 12'hB03, 32'h0);
        idle(1);
        check_lit("wrap_lo", 12'hB03, 32'h0);
        check_lit("wrap_hi", 12'hB83, 32'h0);
        check("wrap_ovf", 64'(hpm_ovf), 64'd1);
        wr(12'hB03, 32'h0);
        check("ovf_clear", 64'(hpm_ovf), 64'd0);

        // Write vs. increment collision
        cyc(16'h0001, 1'b0, 12'hB03, 32'h0);
        wr(12'hB03, 32'h0000_0010);
        check_lit("collide_lo", 12'hB03, 32'h10);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'h0000_0001);
        check_lit("hiwr_lo", 12'hB03, 32'hFFFF_FFFF);
        check_lit("hiwr_hi", 12'hB83, 32'h0000_0001);

        // Unmapped and reserved access
        check_lit("unmapped_rdata", 12'hB00, 32'h0);
        check("unmapped_hit", 64'(csr_hit), 64'd0);
        wr(12'h320, 32'hFFFF_FFFF);
        check_lit("inhibit_rsvd", 12'h320, 32'h18);
        wr(12'h320, 32'h0);

        // Random traffic with a mid-run reset
        for (int i = 0; i < 2000; i++) begin
            a = addr_tab[$urandom_range(11, 0)];
            r = $urandom_range(3, 0);
            d = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'h0 : $urandom;
            if (a == 12'h320 && $urandom_range(1, 0) == 1) d = 32'h0;
            cyc(E'($urandom), ($urandom_range(3, 0) == 0), a, d);
            if (i == 1000) begin
                reset_n = 1'b0;
                model_reset();
                check_lit("rst_mid_lo", 12'hB03, 32'h0);
                check_lit("rst_mid_hi", 12'hB84, 32'h0);
                check_lit("rst_mid_sel", 12'h323, 32'h0);
                check("rst_mid_hit", 64'(csr_hit), 64'd1);
                check("rst_mid_ovf", 64'(hpm_ovf), 64'd0);
                cyc(16'hFFFF, 1'b1, 12'h323, 32'hFFFF);
                reset_n = 1'b1;
                wr(12'h323, 32'h0000_FFFF);
                cyc(16'hFFFF, 1'b0, 12'hB03, 32'h0);
                check_lit("rst_rel_cnt3", 12'hB03, 32'h0);
                idle(1);
                check_lit("rst_rel_cnt3_b", 12'hB03, 32'h1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
